// File: rtl/mux4_arb_pkg.sv
// Shared types and the round-robin pick function for the mux4 register arbiter.
package mux4_arb_pkg;
   localparam int N_REQ = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 4;

   typedef enum logic {IDLE, BUSY} state_t;

   // Returns the first set request scanning last+1, last+2, ... modulo N_REQ.
   // The scan runs from lowest to highest priority, so the highest-priority hit is written last.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [SEL_W-1:0] last);
      logic [SEL_W-1:0] idx;
      rr_pick = last;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = last + SEL_W'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction
endpackage

// File: rtl/mux4_load_reg.sv
// 4:1 data mux feeding a load-enabled register with asynchronous active-low clear.
module mux4_load_reg
   import mux4_arb_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        load,
   input  logic [SEL_W-1:0]            sel,
   input  logic [N_REQ-1:0][WIDTH-1:0] d,
   output logic [WIDTH-1:0]            q
);
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     q <= '0;
      else if (load) q <= d[sel];
   end
endmodule

// File: rtl/mux4_reg_rr_arbiter.sv
// Round-robin scheduler sharing one muxed storage register among four requesters,
// granting each winner a bounded tenure of up to HOLD_CYCLES load cycles.
module mux4_reg_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int HOLD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [3:0]       grant,
   output logic [1:0]       sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q
);
   state_t                      state;
   logic [CNT_W-1:0]            cnt;
   logic [SEL_W-1:0]            last;
   logic [SEL_W-1:0]            pick;
   logic                        load;
   logic [N_REQ-1:0][WIDTH-1:0] d_vec;

   assign d_vec = {d3, d2, d1, d0};
   assign pick  = rr_pick(req, last);
   // sel is registered with the grant, so req[sel] is the current holder's request.
   assign load  = busy & req[sel];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         grant <= '0;
         sel   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
         last  <= SEL_W'(N_REQ - 1);
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  grant <= N_REQ'(1) << pick;
                  sel   <= pick;
                  busy  <= 1'b1;
                  cnt   <= CNT_W'(HOLD_CYCLES - 1);
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0 || !req[sel]) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
                  last  <= sel;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mux4_load_reg #(.WIDTH(WIDTH)) u_load_reg (
      .clk  (clk),
      .rstn (rstn),
      .load (load),
      .sel  (sel),
      .d    (d_vec),
      .q    (q)
   );
endmodule

// File: tb/tb_mux4_reg_rr_arbiter.sv
// Directed bench for mux4_reg_rr_arbiter; observes {grant,sel,busy,done,q} as one vector.
module tb_mux4_reg_rr_arbiter;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] req = '0;
   logic       d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy, done;
   logic       q;
   logic [8:0] obs;
   int checks = 0;
   int failures = 0;

   assign obs = {grant, sel, busy, done, q};

   always #5 clk = ~clk;

   mux4_reg_rr_arbiter #(.WIDTH(1), .HOLD_CYCLES(2)) dut (
      .clk(clk), .rstn(rstn), .req(req),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .grant(grant), .sel(sel), .busy(busy), .done(done), .q(q)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req  = '0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; req = 4'b1111; {d3, d2, d1, d0} = 4'b1111;
      repeat (2) tick();
      checks++;
      if (obs !== 9'b0000_00_0_0_0) begin
         failures++; $display("FAIL reset_state got=%b exp=%b", obs, 9'b0000_00_0_0_0);
      end
      rstn = 1'b1;
      tick();
      checks++;
      if (obs !== 9'b0001_00_1_0_0) begin
         failures++; $display("FAIL reset_first_grant got=%b exp=%b", obs, 9'b0001_00_1_0_0);
      end
      tick();
      checks++;
      if (obs !== 9'b0001_00_1_0_1) begin
         failures++; $display("FAIL reset_first_load got=%b exp=%b", obs, 9'b0001_00_1_0_1);
      end
      tick();
      checks++;
      if (obs !== 9'b0000_00_0_1_1) begin
         failures++; $display("FAIL reset_first_release got=%b exp=%b", obs, 9'b0000_00_0_1_1);
      end
   endtask

   task automatic test_single();
      do_reset();
      {d3, d2, d1, d0} = 4'b0100; req = 4'b0100;
      tick();
      checks++;
      if (obs !== 9'b0100_10_1_0_0) begin
         failures++; $display("FAIL single_grant got=%b exp=%b", obs, 9'b0100_10_1_0_0);
      end
      tick();
      checks++;
      if (obs !== 9'b0100_10_1_0_1) begin
         failures++; $display("FAIL single_load got=%b exp=%b", obs, 9'b0100_10_1_0_1);
      end
      tick();
      checks++;
      if (obs !== 9'b0000_10_0_1_1) begin
         failures++; $display("FAIL single_release got=%b exp=%b", obs, 9'b0000_10_0_1_1);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (obs !== 9'b0000_10_0_0_1) begin
         failures++; $display("FAIL single_done_clear got=%b exp=%b", obs, 9'b0000_10_0_0_1);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] dv;
      logic [8:0] exp;
      logic       qprev;
      do_reset();
      dv = 4'b0101;  // d0..d3 = 1,0,1,0
      {d3, d2, d1, d0} = dv;
      req = 4'b1111;
      qprev = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         exp = {4'b0001 << (n % 4), 2'(n % 4), 1'b1, 1'b0, qprev};
         checks++;
         if (obs !== exp) begin
            failures++; $display("FAIL rot_grant%0d got=%b exp=%b", n, obs, exp);
         end
         tick();
         exp = {4'b0001 << (n % 4), 2'(n % 4), 1'b1, 1'b0, dv[n % 4]};
         checks++;
         if (obs !== exp) begin
            failures++; $display("FAIL rot_load%0d got=%b exp=%b", n, obs, exp);
         end
         tick();
         exp = {4'b0000, 2'(n % 4), 1'b0, 1'b1, dv[n % 4]};
         checks++;
         if (obs !== exp) begin
            failures++; $display("FAIL rot_release%0d got=%b exp=%b", n, obs, exp);
         end
         qprev = dv[n % 4];
      end
   endtask

   task automatic test_early_release();
      do_reset();
      {d3, d2, d1, d0} = 4'b0010; req = 4'b0010;
      tick();
      checks++;
      if (obs !== 9'b0010_01_1_0_0) begin
         failures++; $display("FAIL early_grant got=%b exp=%b", obs, 9'b0010_01_1_0_0);
      end
      req = 4'b0101;
      tick();
      checks++;
      if (obs !== 9'b0000_01_0_1_0) begin
         failures++; $display("FAIL early_release got=%b exp=%b", obs, 9'b0000_01_0_1_0);
      end
      tick();
      checks++;
      if (obs !== 9'b0100_10_1_0_0) begin
         failures++; $display("FAIL early_next_grant got=%b exp=%b", obs, 9'b0100_10_1_0_0);
      end
   endtask

   task automatic test_wrap_skip();
      do_reset();
      {d3, d2, d1, d0} = 4'b0010; req = 4'b0110;
      tick();
      checks++;
      if (obs !== 9'b0010_01_1_0_0) begin
         failures++; $display("FAIL skip_grant1 got=%b exp=%b", obs, 9'b0010_01_1_0_0);
      end
      tick(); tick();
      checks++;
      if (obs !== 9'b0000_01_0_1_1) begin
         failures++; $display("FAIL skip_release1 got=%b exp=%b", obs, 9'b0000_01_0_1_1);
      end
      req = 4'b0100;
      tick();
      checks++;
      if (obs !== 9'b0100_10_1_0_1) begin
         failures++; $display("FAIL skip_grant2 got=%b exp=%b", obs, 9'b0100_10_1_0_1);
      end
      tick();
      req = 4'b1101;  // other requesters rising mid-tenure must not disturb it
      tick();
      checks++;
      if (obs !== 9'b0000_10_0_1_0) begin
         failures++; $display("FAIL skip_release2 got=%b exp=%b", obs, 9'b0000_10_0_1_0);
      end
      tick();
      checks++;
      if (obs !== 9'b1000_11_1_0_0) begin
         failures++; $display("FAIL skip_grant3 got=%b exp=%b", obs, 9'b1000_11_1_0_0);
      end
      req = 4'b1001; d3 = 1'b1;
      tick(); tick();
      checks++;
      if (obs !== 9'b0000_11_0_1_1) begin
         failures++; $display("FAIL wrap_release got=%b exp=%b", obs, 9'b0000_11_0_1_1);
      end
      tick();
      checks++;
      if (obs !== 9'b0001_00_1_0_1) begin
         failures++; $display("FAIL wrap_grant0 got=%b exp=%b", obs, 9'b0001_00_1_0_1);
      end
   endtask

   task automatic test_final_drop();
      do_reset();
      {d3, d2, d1, d0} = 4'b0001; req = 4'b0001;
      tick(); tick();
      checks++;
      if (obs !== 9'b0001_00_1_0_1) begin
         failures++; $display("FAIL final_load got=%b exp=%b", obs, 9'b0001_00_1_0_1);
      end
      req = 4'b0000; d0 = 1'b0;
      tick();
      checks++;
      if (obs !== 9'b0000_00_0_1_1) begin
         failures++; $display("FAIL final_drop_release got=%b exp=%b", obs, 9'b0000_00_0_1_1);
      end
      tick();
      checks++;
      if (obs !== 9'b0000_00_0_0_1) begin
         failures++; $display("FAIL final_drop_idle got=%b exp=%b", obs, 9'b0000_00_0_0_1);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      {d3, d2, d1, d0} = 4'b0100; req = 4'b0100;
      tick(); tick();
      checks++;
      if (obs !== 9'b0100_10_1_0_1) begin
         failures++; $display("FAIL midrst_busy got=%b exp=%b", obs, 9'b0100_10_1_0_1);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (obs !== 9'b0000_00_0_0_0) begin
         failures++; $display("FAIL midrst_async_clear got=%b exp=%b", obs, 9'b0000_00_0_0_0);
      end
      #2 rstn = 1'b1;
      req = 4'b1111; {d3, d2, d1, d0} = 4'b1110;
      tick();
      checks++;
      if (obs !== 9'b0001_00_1_0_0) begin
         failures++; $display("FAIL midrst_regrant got=%b exp=%b", obs, 9'b0001_00_1_0_0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_early_release();
      test_wrap_skip();
      test_final_drop();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mux4_reg_rr_arbiter.md
Name: mux4_reg_rr_arbiter

Overview:
Round-robin scheduler that shares one 4:1-muxed, asynchronously cleared storage register among four requesters. It arbitrates the request lines, drives the mux select and one-hot grant, and loads the selected requester's data into the register for a bounded tenure. It is the sequencing layer that sits directly above the mux-plus-flip-flop datapath in the Chapter 5 register designs.

Parameters:
WIDTH, 1, data width of each requester input and of the shared register q
HOLD_CYCLES, 2, maximum number of load cycles per grant; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
req  input  4  request lines, bit i = requester i (D1..D4 map to i=0..3)
d0  input  WIDTH  data of requester 0
d1  input  WIDTH  data of requester 1
d2  input  WIDTH  data of requester 2
d3  input  WIDTH  data of requester 3
grant  output  4  registered one-hot grant, 0 when idle
sel  output  2  registered mux select, equals index of granted requester
busy  output  1  high while in BUSY state
done  output  1  one-cycle pulse the cycle after a tenure ends
q  output  WIDTH  shared register contents

Behaviour:
- Reset (rstn low, asynchronous, takes effect immediately): state=IDLE, grant=0, sel=0, busy=0, done=0, q=0, cnt=0, last=3 (requester 0 has first priority). Reset asserted mid-tenure aborts it; no done pulse is issued.
- States: IDLE, BUSY.
- IDLE, req==0: remain in IDLE, outputs hold, done=0.
- IDLE, req!=0 at edge k: pick the first set bit scanning last+1, last+2, ... modulo 4. At edge k: grant<=onehot(g), sel<=g, busy<=1, cnt<=HOLD_CYCLES-1, state<=BUSY. q is not loaded at edge k.
- BUSY, at each edge:
  - If req[g]==1, q<=d[sel]. If req[g]==0, q holds.
  - Release condition: cnt==0 or req[g]==0.
  - On release: state<=IDLE, grant<=0, busy<=0, last<=g, done<=1. sel holds its value.
  - Otherwise: cnt<=cnt-1.
- With HOLD_CYCLES=2 and req[g] held high, q loads at edges k+1 and k+2, and release happens at edge k+2.
- done is high only during the cycle following a release edge. It is cleared at every other edge.
- After a release there is always one IDLE cycle before the next grant. The earliest new grant is edge k+HOLD_CYCLES+1.
- Changes on the req bits of non-granted requesters during BUSY have no effect.
- If req[g] drops on the final-count edge, the release still occurs, done still pulses, and q is not loaded on that edge.
- All outputs are registered. There is no combinational path from req or d* to any output.
- Round-robin pointer last wraps from 3 to 0.
- Fairness: with all four requests held high, grants rotate 0,1,2,3,0,...

Decomposition:
- Shared package mux4_arb_pkg holds:
  - state enum {IDLE, BUSY}
  - N_REQ=4
  - SEL_W=2
  - CNT_W=4
  - function rr_pick(req, last) returning the 2-bit winner index.
- Natural sub-module: mux4_load_reg. It contains the WIDTH-wide 4:1 mux and a register with async active-low clear, load enable and sel. The arbiter instantiates it and drives load = busy & req[sel].

Test Plan:
- Reset: hold rstn=0 with req=4'b1111 -> grant=0, sel=0, busy=0, done=0, q=0. Release rstn -> first grant at the next edge is 4'b0001.
- Single requester: req=4'b0100, d2=1, HOLD_CYCLES=2 -> grant=4'b0100 and sel=2 after 1 edge; q=1 one edge later; release after a second load; done high for exactly 1 cycle; grant=0.
- Rotation: req=4'b1111 held, d0..d3=1,0,1,0 -> grant sequence 0001, 0010, 0100, 1000, 0001, each 2 cycles with a 1-cycle IDLE gap; q follows 1,0,1,0.
- Early release: grant to requester 1, drop req[1] on the first BUSY cycle -> q unchanged, done pulses, last=1, next grant goes to requester 2 if req[2]=1.
- Wrap and skip: last=3, req=4'b0110 -> grant=4'b0010. Then with req=4'b0100 -> grant=4'b0100.
- Mid-tenure reset: pulse rstn low between clock edges while busy=1 -> q, grant and busy clear immediately; no done pulse; last=3.
